// File: rtl/cpu_bus_timer.sv
// CPU bus cycle timer: decodes the length of each CPU bus cycle, emits the cpu_en
// strobe and inserts DRAM-refresh stalls and DMA halts between CPU cycles.
module cpu_bus_timer #(
   parameter int FAST_LEN    = 6,
   parameter int SLOW_LEN    = 8,
   parameter int XSLOW_LEN   = 12,
   parameter int REFRESH_LEN = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] addr,
   input  logic        access,
   input  logic        memsel,
   input  logic        refresh_req,
   input  logic        halt,
   output logic        cpu_en,
   output logic [3:0]  cycle_len,
   output logic        refresh_busy,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_REFRESH,
      ST_HALT
   } state_t;

   localparam logic [3:0] FAST     = 4'(FAST_LEN);
   localparam logic [3:0] SLOW     = 4'(SLOW_LEN);
   localparam logic [3:0] XSLOW    = 4'(XSLOW_LEN);
   localparam logic [5:0] REF_LAST = 6'(REFRESH_LEN - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cycle_len_q, cycle_len_d;
   logic [5:0]  ref_cnt_q, ref_cnt_d;
   logic        pending_q, pending_d;
   logic        cpu_en_q, cpu_en_d;
   logic        busy_q, busy_d;
   logic        halted_q, halted_d;
   logic        take_boundary;
   logic        enter_refresh;
   logic [3:0]  decoded_len;
   logic [7:0]  bank;
   logic [15:0] offset;

   assign bank   = addr[23:16];
   assign offset = addr[15:0];

   // Banks $40-$7F/$C0-$FF have bit 6 set; the rest are split by offset.
   always_comb begin
      decoded_len = SLOW;
      if (!access)
         decoded_len = FAST;
      else if (bank[6] || offset[15])
         decoded_len = (bank[7] && memsel) ? FAST : SLOW;
      else if (offset < 16'h2000)
         decoded_len = SLOW;
      else if (offset < 16'h4000)
         decoded_len = FAST;
      else if (offset < 16'h4200)
         decoded_len = XSLOW;
      else if (offset < 16'h6000)
         decoded_len = FAST;
      else
         decoded_len = SLOW;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cycle_len_d   = cycle_len_q;
      ref_cnt_d     = ref_cnt_q;
      cpu_en_d      = 1'b0;
      take_boundary = 1'b0;
      enter_refresh = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (cnt_q == 4'd0)
               take_boundary = 1'b1;
            else if (cnt_q == cycle_len_q - 4'd1) begin
               cpu_en_d = 1'b1;
               cnt_d    = 4'd0;
            end else
               cnt_d = cnt_q + 4'd1;
         end
         ST_REFRESH: begin
            if (ref_cnt_q == REF_LAST)
               take_boundary = 1'b1;
            else
               ref_cnt_d = ref_cnt_q + 6'd1;
         end
         ST_HALT: begin
            if (!halt) begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      endcase

      // Boundary priority: pending refresh, then DMA halt, then a new CPU cycle.
      if (take_boundary) begin
         if (pending_q) begin
            state_d       = ST_REFRESH;
            ref_cnt_d     = 6'd0;
            cnt_d         = 4'd0;
            enter_refresh = 1'b1;
         end else if (halt) begin
            state_d = ST_HALT;
            cnt_d   = 4'd0;
         end else begin
            state_d     = ST_RUN;
            cycle_len_d = decoded_len;
            cnt_d       = 4'd1;
         end
      end

      pending_d = refresh_req | (pending_q & ~enter_refresh);
      busy_d    = (state_d == ST_REFRESH);
      halted_d  = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         cnt_q       <= 4'd0;
         cycle_len_q <= FAST;
         ref_cnt_q   <= 6'd0;
         pending_q   <= 1'b0;
         cpu_en_q    <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cycle_len_q <= cycle_len_d;
         ref_cnt_q   <= ref_cnt_d;
         pending_q   <= pending_d;
         cpu_en_q    <= cpu_en_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign cpu_en       = cpu_en_q;
   assign cycle_len    = cycle_len_q;
   assign refresh_busy = busy_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_cpu_bus_timer.sv
// Bench for cpu_bus_timer: timestamp-based reference model checked every cycle,
// plus directed period/stall checks with hand-computed edge numbers.
module tb_cpu_bus_timer;

   localparam int FAST_LEN    = 6;
   localparam int SLOW_LEN    = 8;
   localparam int XSLOW_LEN   = 12;
   localparam int REFRESH_LEN = 40;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] addr = 24'h7E0000;
   logic        access = 1'b1;
   logic        memsel = 1'b0;
   logic        refresh_req = 1'b0;
   logic        halt = 1'b0;
   logic        cpu_en;
   logic [3:0]  cycle_len;
   logic        refresh_busy;
   logic        halted;

   int total = 0;
   int bad = 0;
   int edge_count = 0;

   cpu_bus_timer #(
      .FAST_LEN(FAST_LEN), .SLOW_LEN(SLOW_LEN),
      .XSLOW_LEN(XSLOW_LEN), .REFRESH_LEN(REFRESH_LEN)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .access(access), .memsel(memsel),
      .refresh_req(refresh_req), .halt(halt), .cpu_en(cpu_en), .cycle_len(cycle_len),
      .refresh_busy(refresh_busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) edge_count <= 0;
      else       edge_count <= edge_count + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int model_len(input logic [23:0] a, input logic acc, input logic ms);
      int bank;
      int off;
      bank = int'(a[23:16]);
      off  = int'(a[15:0]);
      if (!acc) return FAST_LEN;
      if (bank >= 'h40 && bank <= 'h7F) return SLOW_LEN;
      if (bank >= 'hC0) return ms ? FAST_LEN : SLOW_LEN;
      if (off < 'h2000) return SLOW_LEN;
      if (off < 'h4000) return FAST_LEN;
      if (off < 'h4200) return XSLOW_LEN;
      if (off < 'h6000) return FAST_LEN;
      if (off < 'h8000) return SLOW_LEN;
      return (bank >= 'h80 && ms) ? FAST_LEN : SLOW_LEN;
   endfunction

   // Reference model in absolute clock numbers: when the next boundary falls,
   // when the current cycle's strobe is due, and when the refresh stall ends.
   int tick = 0;
   int m_boundary = -1;
   int m_cyc_end = -1;
   int m_busy_end = -1;
   bit m_pending = 0;
   bit m_halting = 0;
   bit model_valid = 0;
   int exp_len = FAST_LEN;
   bit exp_en = 0;
   bit exp_busy = 0;
   bit exp_halted = 0;

   always @(posedge clk) begin
      int len;
      tick = tick + 1;
      model_valid = 1;
      if (reset) begin
         m_pending  = 0;
         m_halting  = 0;
         m_boundary = tick + 1;
         m_cyc_end  = -1;
         m_busy_end = -1;
         exp_len    = FAST_LEN;
      end else begin
         if (tick == m_boundary) begin
            if (m_pending) begin
               m_pending  = 0;
               m_busy_end = tick + REFRESH_LEN - 1;
               m_boundary = tick + REFRESH_LEN;
            end else if (halt) begin
               m_halting  = 1;
               m_boundary = -1;
            end else begin
               len        = model_len(addr, access, memsel);
               exp_len    = len;
               m_cyc_end  = tick + len - 1;
               m_boundary = tick + len;
            end
         end else if (m_halting && !halt) begin
            m_halting  = 0;
            m_boundary = tick + 1;
         end
         if (refresh_req) m_pending = 1;
      end
      exp_en     = !reset && (tick == m_cyc_end);
      exp_busy   = !reset && (tick <= m_busy_end);
      exp_halted = m_halting;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("cpu_en", 32'(cpu_en), 32'(exp_en));
         checkOutput("cycle_len", 32'(cycle_len), 32'(exp_len));
         checkOutput("refresh_busy", 32'(refresh_busy), 32'(exp_busy));
         checkOutput("halted", 32'(halted), 32'(exp_halted));
      end
   end

   task automatic applyStimulus(input logic [23:0] a, input logic acc, input logic ms);
      addr   = a;
      access = acc;
      memsel = ms;
   endtask

   // Waits for the next cpu_en, counting busy/halted cycles seen on the way.
   task automatic waitEn(output int edge_at, output int busy_cnt, output int halt_cnt);
      edge_at  = -1;
      busy_cnt = 0;
      halt_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cpu_en === 1'b1) begin
            edge_at = edge_count;
            break;
         end
         busy_cnt += int'(refresh_busy);
         halt_cnt += int'(halted);
      end
      if (edge_at < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_cpu_en: got timeout expected strobe within 200 clks");
      end
   endtask

   task automatic measurePeriod(input string name, input logic [23:0] a, input logic acc,
                                input logic ms, input int expected);
      int e1, e2, b, h;
      waitEn(e1, b, h);
      applyStimulus(a, acc, ms);
      waitEn(e2, b, h);
      checkOutput(name, 32'(e2 - e1), 32'(expected));
   endtask

   initial begin
      int e0, e1, e2, e3, b, h, b2, h2;

      applyStimulus(24'h7E0000, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("reset_cpu_en", 32'(cpu_en), 32'd0);
      checkOutput("reset_cycle_len", 32'(cycle_len), 32'd6);
      checkOutput("reset_busy", 32'(refresh_busy), 32'd0);
      checkOutput("reset_halted", 32'(halted), 32'd0);
      reset = 1'b0;

      waitEn(e0, b, h);
      checkOutput("first_en_clk", 32'(e0), 32'd8);
      checkOutput("first_cycle_len", 32'(cycle_len), 32'd8);
      waitEn(e0, b, h);
      checkOutput("second_en_clk", 32'(e0), 32'd16);
      waitEn(e0, b, h);
      checkOutput("third_en_clk", 32'(e0), 32'd24);

      measurePeriod("joypad_period", 24'h004016, 1'b1, 1'b0, 12);
      measurePeriod("ppu_period", 24'h002100, 1'b1, 1'b0, 6);
      measurePeriod("internal_period", 24'h7E0000, 1'b0, 1'b0, 6);
      measurePeriod("fastrom_period", 24'h808000, 1'b1, 1'b1, 6);
      measurePeriod("slowrom_period", 24'h808000, 1'b1, 1'b0, 8);
      measurePeriod("lowbank_rom_period", 24'h008000, 1'b1, 1'b1, 8);
      measurePeriod("hibank_fast_period", 24'hC00000, 1'b1, 1'b1, 6);
      measurePeriod("wram_mirror_top", 24'h001FFF, 1'b1, 1'b1, 8);
      measurePeriod("xslow_top", 24'h8041FF, 1'b1, 1'b1, 12);
      measurePeriod("cpu_regs_start", 24'h004200, 1'b1, 1'b0, 6);
      measurePeriod("expansion_start", 24'h006000, 1'b1, 1'b1, 8);
      measurePeriod("bank40_memsel", 24'h400000, 1'b1, 1'b1, 8);
      measurePeriod("back_to_slow", 24'h7E0000, 1'b1, 1'b0, 8);

      // Single refresh request mid-cycle.
      waitEn(e0, b, h);
      repeat (3) @(negedge clk);
      refresh_req = 1'b1;
      @(negedge clk);
      refresh_req = 1'b0;
      waitEn(e1, b, h);
      checkOutput("refresh_current_on_time", 32'(e1 - e0), 32'd8);
      waitEn(e2, b2, h2);
      checkOutput("refresh_gap", 32'(e2 - e1), 32'd48);
      checkOutput("refresh_busy_clks", 32'(b2), 32'd40);

      // Two requests before the boundary merge into one stall.
      waitEn(e0, b, h);
      @(negedge clk); refresh_req = 1'b1;
      @(negedge clk); refresh_req = 1'b0;
      @(negedge clk); refresh_req = 1'b1;
      @(negedge clk); refresh_req = 1'b0;
      waitEn(e1, b, h);
      waitEn(e2, b2, h2);
      checkOutput("merged_refresh_gap", 32'(e2 - e1), 32'd48);
      checkOutput("merged_busy_clks", 32'(b2), 32'd40);
      waitEn(e3, b, h);
      checkOutput("after_merged_period", 32'(e3 - e2), 32'd8);

      // Halt raised mid-cycle for 20 clks with a refresh request arriving while halted.
      waitEn(e0, b, h);
      fork
         begin
            repeat (2) @(negedge clk);
            halt = 1'b1;
            repeat (12) @(negedge clk);
            refresh_req = 1'b1;
            @(negedge clk);
            refresh_req = 1'b0;
            repeat (7) @(negedge clk);
            halt = 1'b0;
         end
         begin
            waitEn(e1, b, h);
            waitEn(e2, b2, h2);
         end
      join
      checkOutput("halt_current_on_time", 32'(e1 - e0), 32'd8);
      checkOutput("halt_refresh_gap", 32'(e2 - e1), 32'd63);
      checkOutput("halted_clks", 32'(h2), 32'd14);
      checkOutput("halt_refresh_busy_clks", 32'(b2), 32'd40);
      waitEn(e3, b, h);
      checkOutput("after_halt_period", 32'(e3 - e2), 32'd8);

      // Reset at cnt = 5 of a 12-clk cycle.
      applyStimulus(24'h004016, 1'b1, 1'b0);
      waitEn(e0, b, h);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset_cpu_en", 32'(cpu_en), 32'd0);
      checkOutput("midreset_cycle_len", 32'(cycle_len), 32'd6);
      checkOutput("midreset_busy", 32'(refresh_busy), 32'd0);
      checkOutput("midreset_halted", 32'(halted), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      waitEn(e1, b, h);
      checkOutput("post_reset_first_en", 32'(e1), 32'd12);
      checkOutput("post_reset_cycle_len", 32'(cycle_len), 32'd12);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
